disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
//  Time-multiplexed display scan controller for the 8-position board/status display.
//  Walks a 3-bit select across 8 positions and drives the select of the downstream
//  8:1 N-bit mux. Registers the mux's returned value per position and drives the
//  active-low anode enables, with a blanking gap between positions to stop ghosting.
//  Sits between the board-state registers (into the mux) and the segment decoder/pins.
// PARAMETERS
//  N          3       width of each mux data word, mux_f and digit_val
//  BLANK_CYC  1000    cycles all anodes are off before each capture (>=1)
//  DWELL_CYC  100000  cycles a position's anode stays on (>=1)
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  en         in   1  scan enable; 0 = blank display and hold position
//  digit_en   in   8  per-position enable mask; bit i = position i may light
//  mux_f      in   N  word returned by the 8:1 mux for the current sel
//  sel        out  3  position index to the mux select; registered
//  digit_val  out  N  captured mux word for the lit position; registered
//  an         out  8  anode enables, active-low; one-hot-low or all-1; registered
//  frame_tick out  1  one-cycle pulse when sel wraps 7->0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=BLANK, cnt=0, sel=0, digit_val=0, an=8'hFF,
//   frame_tick=0. Reset mid-scan aborts immediately with no clock needed.
//  FSM (cnt = internal counter, width $clog2(max(BLANK_CYC,DWELL_CYC))+1):
//   BLANK:   an=FF; cnt counts 0..BLANK_CYC-1; at cnt==BLANK_CYC-1 -> CAPTURE, cnt=0.
//   CAPTURE: one cycle; digit_val<=mux_f (mux has had >=BLANK_CYC cycles to settle);
//            -> SHOW.
//   SHOW:    lasts exactly DWELL_CYC cycles; at cnt==DWELL_CYC-1 -> BLANK, cnt=0,
//            sel<=sel+1 (7 wraps to 0). frame_tick=1 for the single cycle after
//            the 7->0 update; otherwise 0.
//  Per-position period = BLANK_CYC+1+DWELL_CYC cycles; frame = 8 x period.
//  an is computed from next-state: an <= (next==SHOW) ? ~(onehot(sel)&digit_en) : 8'hFF.
//   an is low exactly during SHOW cycles. A digit_en change takes effect 1 cycle later.
//  Masked position (digit_en[sel]=0): full timing kept, an stays FF, digit_val still updates.
//  sel changes only on SHOW->BLANK, never while an is low. Mux select is stable
//   throughout BLANK/CAPTURE/SHOW.
//  en=0: next cycle state=BLANK, cnt=0, an=FF, frame_tick=0; sel and digit_val held.
//   en re-asserted: full BLANK then CAPTURE of the same sel (no skip, no repeat tick).
//  en=0 coincident with the SHOW->BLANK boundary: en wins. sel is not advanced.
//  Never two anodes low; an never low in the cycle sel changes.
// TESTING (bench with BLANK_CYC=2, DWELL_CYC=4, N=3, mux model mux_f=sel+1)
//  1 reset_n=0 -> an=FF, sel=0, digit_val=0, frame_tick=0, no clock edge required.
//  2 release, en=1, digit_en=FF -> an=FF 3 cycles, then digit_val=1, an=FE 4 cycles,
//    then an=FF and sel=1; next lit pattern an=FD with digit_val=2.
//  3 run 56 cycles -> sel sequence 0..7; frame_tick single pulse as sel returns to 0;
//    next pulse exactly 56 cycles later.
//  4 digit_en=8'hFB -> during sel=2 an stays FF for whole period, digit_val=3;
//    sel=3 lights (an=F7) on schedule.
//  5 en=0 in 2nd SHOW cycle of sel=4 -> an=FF next cycle, sel=4 held; en=1 ->
//    2 blank +1 capture cycles, then an=EF for 4 cycles.
//  6 reset_n=0 mid-SHOW of sel=6 -> an=FF, sel=0 immediately; scan restarts per test 2.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan of an 8-position display.
// Drives the mux select, captures the returned word and drives the anodes.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   async active-low reset
//   en         in   scan enable; 0 blanks and holds position
//   digit_en   in   per-position light mask
//   mux_f      in   mux word for the current sel
//   sel        out  mux select / position index
//   digit_val  out  captured word for the lit position
//   an         out  active-low anode enables
//   frame_tick out  pulse after sel wraps 7->0
module disp_scan_ctrl #(
  parameter int N         = 3,
  parameter int BLANK_CYC = 1000,
  parameter int DWELL_CYC = 100000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [7:0]   digit_en,
  input  logic [N-1:0] mux_f,
  output logic [2:0]   sel,
  output logic [N-1:0] digit_val,
  output logic [7:0]   an,
  output logic         frame_tick
);

  localparam int MAXC =
    (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST =
    CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_BLANK,
    S_CAPTURE,
    S_SHOW
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;
  logic [2:0]     sel_nx;
  logic [N-1:0]   dv_nx;
  logic [7:0]     an_nx;
  logic           tick_nx;
  logic [7:0]     onehot;

  assign onehot = 8'b0000_0001 << sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_BLANK;
      cnt        <= '0;
      sel        <= '0;
      digit_val  <= '0;
      an         <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel        <= sel_nx;
      digit_val  <= dv_nx;
      an         <= an_nx;
      frame_tick <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    dv_nx    = digit_val;
    tick_nx  = 1'b0;
    if (!en) begin
      // Disable wins over any boundary: sel is never advanced here.
      state_nx = S_BLANK;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = S_CAPTURE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        S_CAPTURE: begin
          // Mux has settled for the whole blank gap.
          dv_nx    = mux_f;
          state_nx = S_SHOW;
          cnt_nx   = '0;
        end
        S_SHOW: begin
          if (cnt == DWELL_LAST) begin
            state_nx = S_BLANK;
            cnt_nx   = '0;
            sel_nx   = sel + 3'd1;
            tick_nx  = (sel == 3'd7);
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Anodes follow the next state so they are low exactly in SHOW;
  // sel only moves on the SHOW->BLANK edge, where this yields FF.
  always_comb begin
    an_nx = 8'hFF;
    if (state_nx == S_SHOW) begin
      an_nx = ~(onehot & digit_en);
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scenario tasks plus randomized run
// checked against a phase-based reference model.
module tb_disp_scan_ctrl;

  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + 1 + D;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic [2:0] mux_f;
  logic [2:0] sel;
  logic [2:0] digit_val;
  logic [7:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: position index and phase within
  // the B+1+D period (0..B-1 blank, B capture, rest show).
  int         m_phase;
  int         m_sel;
  logic [2:0] m_dv;
  logic [7:0] m_an;
  logic       m_tick;

  logic [14:0] obs;
  logic [14:0] expv;

  disp_scan_ctrl #(
    .N(3),
    .BLANK_CYC(B),
    .DWELL_CYC(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .digit_en(digit_en),
    .mux_f(mux_f),
    .sel(sel),
    .digit_val(digit_val),
    .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  assign mux_f = sel + 3'd1;
  assign obs = {sel, digit_val, an, frame_tick};
  assign expv = {3'(m_sel), m_dv, m_an, m_tick};

  function automatic void m_reset();
    m_phase = 0;
    m_sel = 0;
    m_dv = 3'd0;
    m_an = 8'hFF;
    m_tick = 1'b0;
  endfunction

  function automatic void m_step();
    m_tick = 1'b0;
    if (!en) begin
      m_phase = 0;
      m_an = 8'hFF;
      return;
    end
    if (m_phase == B) m_dv = 3'((m_sel + 1) % 8);
    if (m_phase == P - 1) begin
      m_tick = (m_sel == 7);
      m_sel = (m_sel + 1) % 8;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    m_an = (m_phase > B) ? ~(8'(1 << m_sel) & digit_en)
                         : 8'hFF;
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'b000_000_11111111_0) begin
      n_fail++;
      $display("FAIL reset_async got=%h want=%h",
               obs, 15'b000_000_11111111_0);
    end
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=%h", obs, expv);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_digit(input string nm);
    logic [7:0] ea;
    logic [2:0] es;
    en = 1'b1;
    digit_en = 8'hFF;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick();
      ea = (i < 3 || (i >= 7 && i < 10)) ? 8'hFF :
           (i < 7) ? 8'hFE : 8'hFD;
      es = (i < 7) ? 3'd0 : 3'd1;
      n_checks++;
      if ({es, ea} !== {sel, an}) begin
        n_fail++;
        $display("FAIL %s_cyc%0d sel/an got=%h/%h want=%h/%h",
                 nm, i, sel, an, es, ea);
      end
      if (i == 3 || i == 10) begin
        n_checks++;
        if (digit_val !== ((i == 3) ? 3'd1 : 3'd2)) begin
          n_fail++;
          $display("FAIL %s_dv cyc%0d got=%0d", nm, i, digit_val);
        end
      end
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s_model cyc%0d got=%h want=%h",
                 nm, i, obs, expv);
      end
    end
  endtask

  task automatic test_frame();
    int ticks[$];
    logic [2:0] prev;
    prev = sel;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (frame_tick === 1'b1) begin
        ticks.push_back(i);
        n_checks++;
        if (sel !== 3'd0 || prev !== 3'd7) begin
          n_fail++;
          $display("FAIL frame_wrap sel=%0d prev=%0d", sel, prev);
        end
      end
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL frame_model i=%0d got=%h want=%h",
                 i, obs, expv);
      end
      prev = sel;
    end
    n_checks++;
    if (ticks.size() < 2) begin
      n_fail++;
      $display("FAIL frame_count got=%0d want>=2", ticks.size());
    end else if (ticks[1] - ticks[0] != 8 * P) begin
      n_fail++;
      $display("FAIL frame_period got=%0d want=%0d",
               ticks[1] - ticks[0], 8 * P);
    end
  endtask

  task automatic wait_pos(input int s, input int ph,
                          input string nm);
    for (int k = 0; k < 200; k++) begin
      if (m_sel == s && m_phase == ph) break;
      tick();
    end
    n_checks++;
    if (!(m_sel == s && m_phase == ph)) begin
      n_fail++;
      $display("FAIL %s_reach sel=%0d phase=%0d", nm, m_sel, m_phase);
    end
  endtask

  task automatic test_mask();
    digit_en = 8'hFB;
    wait_pos(2, 0, "mask");
    for (int j = 0; j <= P + B + 1; j++) begin
      if (j > 0) tick();
      if (j < P) begin
        n_checks++;
        if (an !== 8'hFF) begin
          n_fail++;
          $display("FAIL mask_dark j=%0d an got=%h want=ff", j, an);
        end
      end
      if (j == B + 1) begin
        n_checks++;
        if (digit_val !== 3'd3) begin
          n_fail++;
          $display("FAIL mask_dv got=%0d want=3", digit_val);
        end
      end
      if (j == P + B + 1) begin
        n_checks++;
        if ({sel, an} !== {3'd3, 8'hF7}) begin
          n_fail++;
          $display("FAIL mask_next sel/an got=%0d/%h want=3/f7",
                   sel, an);
        end
      end
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mask_model j=%0d got=%h want=%h",
                 j, obs, expv);
      end
    end
  endtask

  task automatic test_en_drop();
    wait_pos(4, B + 2, "endrop");
    n_checks++;
    if (an !== 8'hEF) begin
      n_fail++;
      $display("FAIL endrop_lit an got=%h want=ef", an);
    end
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++;
      if ({sel, an, frame_tick} !== {3'd4, 8'hFF, 1'b0}) begin
        n_fail++;
        $display("FAIL endrop_hold j=%0d sel/an got=%0d/%h want=4/ff",
                 j, sel, an);
      end
    end
    en = 1'b1;
    for (int j = 0; j <= B + D; j++) begin
      if (j > 0) tick();
      n_checks++;
      if ({sel, an} !== {3'd4, (j <= B) ? 8'hFF : 8'hEF}) begin
        n_fail++;
        $display("FAIL endrop_resume j=%0d sel/an got=%0d/%h",
                 j, sel, an);
      end
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL endrop_model j=%0d got=%h want=%h",
                 j, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    digit_en = 8'hFF;
    wait_pos(6, B + 2, "rstmid");
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'b000_000_11111111_0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h want=%h",
               obs, 15'b000_000_11111111_0);
    end
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_first_digit("restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 14) == 0) digit_en = 8'($urandom);
      tick();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rand_model i=%0d got=%h want=%h",
                 i, obs, expv);
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL rand_onehot i=%0d an got=%h want<=1 low",
                 i, an);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_digit("first");
    test_frame();
    test_mask();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
